aes_iter_enc: RTL and testbench



---
 rtl/aes_pkg.sv | 63 ++++++
 rtl/aes_sbox.sv | 42 ++++
 rtl/aes_iter_enc.sv | 105 ++++++++++
 tb/tb_aes_iter_enc.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: AES constants, GF(2^8) helpers and FSM encoding shared by the iterative cipher.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_fsm_e;

    function automatic int nr_of(input int key_bits);
        return (key_bits == 256) ? 14 : 10;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Column word holds row 0 in its most significant byte.
    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        for (int c = 0; c < 4; c++) s[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
        return s;
    endfunction

    // Byte k sits at row k%4, column k/4; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: forward AES S-box as a purely combinational lookup table.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    always_comb begin
        case (a)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; default: s = 8'h16;
        endcase
    end
endmodule

// File: rtl/aes_iter_enc.sv
// aes_iter_enc: iterative AES-128/256 encryptor, one round per clock, on-the-fly key expansion,
// valid/ready on both sides with output backpressure.
module aes_iter_enc
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [KEY_BITS-1:0] in_key,
    input  logic [127:0]        in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data,
    output logic                busy
);
    localparam int NR    = nr_of(KEY_BITS);
    localparam bit IS256 = (KEY_BITS == 256);

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_iter_enc: KEY_BITS must be 128 or 256");
    end

    aes_fsm_e     fsm, fsm_nx;
    logic [3:0]   rnd, rnd_p1;
    logic [127:0] st, k_a, k_b;
    logic [127:0] sb, sr, rnd_out, rk, k_exp, k_src;
    logic [31:0]  sw_in, sw_out, temp, w0, w1, w2, w3;
    logic [7:0]   rc;
    logic         accept, last, use_rot;

    for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
        aes_sbox u_sbox (.a(st[8*i +: 8]), .s(sb[8*i +: 8]));
    end

    for (genvar i = 0; i < 4; i++) begin : g_sub_word
        aes_sbox u_sbox (.a(sw_in[8*i +: 8]), .s(sw_out[8*i +: 8]));
    end

    // k_a holds the previous round key; for 256-bit keys k_b already holds the current one
    // and the expansion produces the key two rounds ahead from k_a and the last word of k_b.
    assign rnd_p1  = rnd + 4'd1;
    assign k_src   = IS256 ? k_b : k_a;
    assign use_rot = !IS256 || rnd[0];
    assign sw_in   = use_rot ? rot_word(k_src[31:0]) : k_src[31:0];
    assign rc      = use_rot ? rcon(IS256 ? (rnd_p1 >> 1) : rnd) : 8'h00;
    assign temp    = sw_out ^ {rc, 24'h0};
    assign w0      = k_a[127:96] ^ temp;
    assign w1      = k_a[95:64] ^ w0;
    assign w2      = k_a[63:32] ^ w1;
    assign w3      = k_a[31:0] ^ w2;
    assign k_exp   = {w0, w1, w2, w3};
    assign rk      = IS256 ? k_b : k_exp;

    always_comb begin
        sr      = shift_rows(sb);
        rnd_out = (last ? sr : mix_columns(sr)) ^ rk;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm <= IDLE;
        else        fsm <= fsm_nx;
    end

    always_comb begin
        fsm_nx = fsm;
        case (fsm)
            IDLE:    fsm_nx = accept ? RUN : IDLE;
            RUN:     fsm_nx = last ? DONE : RUN;
            DONE:    fsm_nx = out_ready ? (in_valid ? RUN : IDLE) : DONE;
            default: fsm_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (fsm == IDLE) || (fsm == DONE && out_ready);
        out_valid = (fsm == DONE);
        busy      = (fsm == RUN);
        accept    = in_valid && in_ready;
        last      = (fsm == RUN) && (rnd == 4'(NR));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd      <= '0;
            st       <= '0;
            k_a      <= '0;
            k_b      <= '0;
            out_data <= '0;
        end else if (accept) begin
            rnd <= 4'd1;
            st  <= in_data ^ in_key[KEY_BITS-1 -: 128];
            k_a <= in_key[KEY_BITS-1 -: 128];
            k_b <= in_key[127:0];
        end else if (busy) begin
            rnd <= last ? 4'd0 : rnd_p1;
            st  <= rnd_out;
            k_a <= rk;
            k_b <= k_exp;
            if (last) out_data <= rnd_out;
        end
    end
endmodule

// File: tb/tb_aes_iter_enc.sv
// tb_aes_iter_enc: checks 128- and 256-bit cores against known answers and an array-based AES model.
module tb_aes_iter_enc;

    typedef struct {
        bit           is256;
        logic [255:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        iv, ir, ov, ordy, bz;
    logic [1:0][127:0] id, od;
    logic [127:0]      k128;
    logic [255:0]      k256;
    logic [7:0]        sb_m [256];
    int                total = 0;
    int                bad = 0;
    vec_t              vecs [3];

    always #5 clk = ~clk;

    aes_iter_enc #(.KEY_BITS(128)) u128 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_key(k128),
        .in_data(id[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .busy(bz[0])
    );

    aes_iter_enc #(.KEY_BITS(256)) u256 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_key(k256),
        .in_data(id[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .busy(bz[1])
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb_m[w[31:24]], sb_m[w[23:16]], sb_m[w[15:8]], sb_m[w[7:0]]};
    endfunction

    // Textbook cipher over a byte array and a full expanded word schedule; key is left-aligned.
    function automatic logic [127:0] aes_ref(input bit is256, input logic [255:0] key, input logic [127:0] pt);
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rcv;
        logic [127:0] res;
        int           nk, nr;
        nk  = is256 ? 8 : 4;
        nr  = is256 ? 14 : 10;
        rcv = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rcv, 24'h0};
                rcv = gmul(rcv, 8'h02);
            end else if (nk == 8 && i % 8 == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int k = 0; k < 16; k++) t[k] = sb_m[s[k]];
            for (int k = 0; k < 16; k++) s[k] = t[k%4 + 4*((k/4 + k%4) % 4)];
            if (r < nr) begin
                for (int k = 0; k < 16; k++) t[k] = s[k];
                for (int c = 0; c < 4; c++)
                    for (int i = 0; i < 4; i++)
                        s[4*c+i] = gmul(t[4*c+i], 8'h02) ^ gmul(t[4*c+(i+1)%4], 8'h03)
                                 ^ t[4*c+(i+2)%4] ^ t[4*c+(i+3)%4];
            end
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[4*r + k/4][31-8*(k%4) -: 8];
        end
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(input int s, input logic [255:0] key, input logic [127:0] pt);
        id[s] = pt;
        if (s == 0) k128 = key[255:128];
        else        k256 = key;
    endtask

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic start(input int s, input logic [255:0] key, input logic [127:0] pt);
        int n;
        n = 0;
        drive(s, key, pt);
        iv[s] = 1'b1;
        while (!ir[s] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("start_ready", 128'(ir[s]), 128'd1);
        @(negedge clk);
        iv[s] = 1'b0;
    endtask

    // Counts edges until out_valid, checking RUN behaviour; optionally scrambles inputs meanwhile.
    task automatic wait_out(input int s, input logic [127:0] exp, input int lat, input bit scr);
        int           n;
        bit           ok;
        logic [127:0] prev;
        n    = 0;
        ok   = 1'b1;
        prev = od[s];
        while (!ov[s] && n < 40) begin
            if (ir[s] || !bz[s] || od[s] !== prev) ok = 1'b0;
            if (scr) begin
                iv[s] = 1'($urandom_range(0, 1));
                drive(s, {rand128(), rand128()}, rand128());
            end
            @(negedge clk);
            n++;
        end
        iv[s] = 1'b0;
        chk("run_ctl", 128'(ok), 128'd1);
        chk("latency", 128'(n), 128'(lat));
        chk("out_data", od[s], exp);
    endtask

    task automatic expect_idle(input int s);
        @(negedge clk);
        chk("idle", 128'({ov[s], ir[s], bz[s]}), 128'(3'b010));
    endtask

    initial begin
        logic [7:0]   inv, b, rr, sv;
        logic [255:0] key;
        logic [127:0] pt, exp;
        int           s, stall;

        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++) if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            b  = inv;
            sv = inv;
            rr = inv;
            for (int k = 0; k < 4; k++) begin
                rr = {rr[6:0], rr[7]};
                sv = sv ^ rr;
            end
            sb_m[a] = sv ^ 8'h63;
        end

        vecs[0] = '{1'b0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                    128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{1'b0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                    128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{1'b1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089};

        iv   = 2'b00;
        ordy = 2'b11;
        id   = '0;
        k128 = '0;
        k256 = '0;
        repeat (3) @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            chk("rst_out_data", od[j], 128'h0);
            chk("rst_ctl", 128'({ov[j], bz[j]}), 128'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 2; j++) chk("rst_in_ready", 128'(ir[j]), 128'd1);

        for (int v = 0; v < 3; v++) begin
            s = vecs[v].is256 ? 1 : 0;
            start(s, vecs[v].key, vecs[v].pt);
            wait_out(s, vecs[v].ct, s ? 14 : 10, 1'b0);
            expect_idle(s);
        end

        // Backpressure, then back-to-back accept on the releasing edge.
        ordy[0] = 1'b0;
        start(0, vecs[1].key, vecs[1].pt);
        wait_out(0, vecs[1].ct, 10, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_data", od[0], vecs[1].ct);
            chk("bp_ctl", 128'({ov[0], ir[0]}), 128'(2'b10));
        end
        ordy[0] = 1'b1;
        iv[0]   = 1'b1;
        drive(0, vecs[0].key, vecs[0].pt);
        #1 chk("b2b_ready", 128'(ir[0]), 128'd1);
        @(negedge clk);
        iv[0] = 1'b0;
        chk("b2b_accept", 128'({ov[0], bz[0]}), 128'(2'b01));
        chk("b2b_hold", od[0], vecs[1].ct);
        wait_out(0, vecs[0].ct, 10, 1'b0);
        expect_idle(0);

        // Inputs changing every cycle during RUN must not affect the result.
        start(0, vecs[1].key, vecs[1].pt);
        wait_out(0, vecs[1].ct, 10, 1'b1);
        expect_idle(0);
        start(1, vecs[2].key, vecs[2].pt);
        wait_out(1, vecs[2].ct, 14, 1'b1);
        expect_idle(1);

        // Reset in the middle of round processing.
        start(0, vecs[1].key, vecs[1].pt);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstrun_ctl", 128'({ov[0], bz[0]}), 128'd0);
        chk("rstrun_data", od[0], 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstrun_idle", 128'({ov[0], ir[0], bz[0]}), 128'(3'b010));
        stall = 0;
        repeat (12) begin
            @(negedge clk);
            if (ov[0] || bz[0]) stall++;
        end
        chk("rstrun_quiet", 128'(stall), 128'd0);
        start(0, vecs[0].key, vecs[0].pt);
        wait_out(0, vecs[0].ct, 10, 1'b0);
        expect_idle(0);

        // Reset while a result waits for the consumer.
        ordy[1] = 1'b0;
        start(1, vecs[2].key, vecs[2].pt);
        wait_out(1, vecs[2].ct, 14, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstdone_ctl", 128'({ov[1], bz[1]}), 128'd0);
        chk("rstdone_data", od[1], 128'h0);
        @(negedge clk);
        rst_n   = 1'b1;
        ordy[1] = 1'b1;
        @(negedge clk);
        chk("rstdone_idle", 128'({ov[1], ir[1], bz[1]}), 128'(3'b010));

        for (int n = 0; n < 24; n++) begin
            s     = n % 2;
            key   = {rand128(), rand128()};
            pt    = rand128();
            exp   = aes_ref(s == 1, key, pt);
            stall = $urandom_range(0, 3);
            ordy[s] = (stall == 0);
            start(s, key, pt);
            wait_out(s, exp, s ? 14 : 10, 1'($urandom_range(0, 1)));
            if (stall != 0) begin
                repeat (stall) @(negedge clk);
                chk("rand_stall", 128'({ov[s], ir[s]}), 128'(2'b10));
                ordy[s] = 1'b1;
            end
            expect_idle(s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
